mem_line_responder: RTL

// - Memory-side responder for the cache's line request/response interface (mrq_* in, mrs_* out).
// - Serves each line-sized read or write by sequencing LINE_WORDS accesses to a single-port word RAM.
// - Returns a one-cycle ack, with read data, once the whole line is done.
// - Sits between riscv_cache_top and the reference_ram-style altsyncram (12-bit word address, 32-bit data).

---
 rtl/mem_line_responder_if.sv | 29 ++
 rtl/mem_line_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder_if.sv
// Line request/response bundle between the cache, the line responder and the word RAM.
// The master modport is the cache plus RAM side; the slave modport is the responder.
interface mem_line_responder_if #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 2,
    parameter int RAM_AW     = 12
);
    logic                         mrq_cs;
    logic                         mrq_rw;
    logic [ADDR_W-1:0]            mrq_addr;
    logic [LINE_WORDS*WORD_W-1:0] mrq_data;
    logic                         mrs_ack;
    logic [LINE_WORDS*WORD_W-1:0] mrs_data;
    logic [RAM_AW-1:0]            ram_address;
    logic                         ram_wren;
    logic [WORD_W-1:0]            ram_data;
    logic [WORD_W-1:0]            ram_q;

    modport master (
        output mrq_cs, mrq_rw, mrq_addr, mrq_data, ram_q,
        input  mrs_ack, mrs_data, ram_address, ram_wren, ram_data
    );

    modport slave (
        input  mrq_cs, mrq_rw, mrq_addr, mrq_data, ram_q,
        output mrs_ack, mrs_data, ram_address, ram_wren, ram_data
    );
endinterface

// File: rtl/mem_line_responder.sv
// Serves cache line reads/writes by sequencing LINE_WORDS accesses to a single-port word RAM.
// Optional MEMRSP_PERF_CNT_EN adds saturating rd_count/wr_count line counters.
module mem_line_responder #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 2,
    parameter int RAM_AW     = 12
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MEMRSP_PERF_CNT_EN
    output logic [15:0]            rd_count,
    output logic [15:0]            wr_count,
`endif
    mem_line_responder_if.slave    bus
);
    localparam int IDX_W  = $clog2(LINE_WORDS);
    localparam int STEP_W = IDX_W + 1;
    localparam int LINE_W = LINE_WORDS * WORD_W;
    localparam logic [STEP_W-1:0] LAST_WR_STEP = STEP_W'(LINE_WORDS - 1);
    localparam logic [STEP_W-1:0] LAST_RD_STEP = STEP_W'(LINE_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_RESP,
        ST_RELEASE
    } state_e;

    state_e              state_q;
    logic [RAM_AW-1:0]   base_q;
    logic [LINE_W-1:0]   wline_q;
    logic [STEP_W-1:0]   step_q;
    logic                mrs_ack_q;
    logic [LINE_W-1:0]   mrs_data_q;
    logic [RAM_AW-1:0]   ram_address_q;
    logic                ram_wren_q;
    logic [WORD_W-1:0]   ram_data_q;

    logic [RAM_AW-1:0]   req_base;
    logic [IDX_W-1:0]    nxt_idx;
    logic [IDX_W-1:0]    cap_idx;
    logic                unused_addr_bits;

    // Word address of the line: byte offset dropped, word-in-line bits cleared, upper bits wrap.
    assign req_base = bus.mrq_addr[RAM_AW+1:2] & ~RAM_AW'((1 << IDX_W) - 1);
    assign unused_addr_bits = ^{bus.mrq_addr[ADDR_W-1:RAM_AW+2], bus.mrq_addr[1:0]};

    // step_q counts clock edges spent in WRITE/READ; a read word returns one edge after its address.
    assign nxt_idx = step_q[IDX_W-1:0] + IDX_W'(1);
    assign cap_idx = step_q[IDX_W-1:0] - IDX_W'(1);

    // NOTE: every register below uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            base_q        <= '0;
            // NOTE: the line buffer is reset too; it is a plain register, not a RAM macro.
            wline_q       <= '0;
            step_q        <= '0;
            mrs_ack_q     <= 1'b0;
            mrs_data_q    <= '0;
            ram_address_q <= '0;
            ram_wren_q    <= 1'b0;
            ram_data_q    <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.mrq_cs) begin
                        base_q        <= req_base;
                        wline_q       <= bus.mrq_data;
                        step_q        <= '0;
                        ram_address_q <= req_base;
                        if (bus.mrq_rw) begin
                            ram_wren_q <= 1'b1;
                            ram_data_q <= bus.mrq_data[WORD_W-1:0];
                            state_q    <= ST_WRITE;
                        end else begin
                            state_q    <= ST_READ;
                        end
                    end
                end

                ST_WRITE: begin
                    if (step_q == LAST_WR_STEP) begin
                        ram_wren_q <= 1'b0;
                        mrs_ack_q  <= 1'b1;
                        state_q    <= ST_RESP;
                    end else begin
                        ram_address_q <= base_q | RAM_AW'(nxt_idx);
                        ram_data_q    <= wline_q[nxt_idx*WORD_W +: WORD_W];
                        step_q        <= step_q + 1'b1;
                    end
                end

                ST_READ: begin
                    if (step_q != '0) begin
                        mrs_data_q[cap_idx*WORD_W +: WORD_W] <= bus.ram_q;
                    end
                    if (step_q == LAST_RD_STEP) begin
                        mrs_ack_q <= 1'b1;
                        state_q   <= ST_RESP;
                    end else begin
                        if (step_q < LAST_WR_STEP) begin
                            ram_address_q <= base_q | RAM_AW'(nxt_idx);
                        end
                        step_q <= step_q + 1'b1;
                    end
                end

                ST_RESP: begin
                    mrs_ack_q <= 1'b0;
                    state_q   <= ST_RELEASE;
                end

                // A request held high across its ack must not be served a second time.
                ST_RELEASE: begin
                    if (!bus.mrq_cs) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.mrs_ack     = mrs_ack_q;
    assign bus.mrs_data    = mrs_data_q;
    assign bus.ram_address = ram_address_q;
    assign bus.ram_wren    = ram_wren_q;
    assign bus.ram_data    = ram_data_q;

`ifdef MEMRSP_PERF_CNT_EN
    logic        rw_q;
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q       <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            if (state_q == ST_IDLE && bus.mrq_cs) begin
                rw_q <= bus.mrq_rw;
            end
            if (state_q == ST_RESP) begin
                if (rw_q && wr_count_q != 16'hFFFF) begin
                    wr_count_q <= wr_count_q + 16'd1;
                end
                if (!rw_q && rd_count_q != 16'hFFFF) begin
                    rd_count_q <= rd_count_q + 16'd1;
                end
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif
endmodule
